spi_master_arb: RTL and testbench

SPI_MASTER_ARB -- requirements
Module: spi_master_arb

---
 rtl/spi_master_arb.sv | 142 ++++++++++++++
 tb/tb_spi_master_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
// Two-requester SPI master (mode 0, MSB first) with round-robin arbitration.
// One frame per grant: SETUP, 16 SCK half-periods, HOLD, then a GAP before re-arbitration.
module spi_master_arb #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] RDATA,
    output logic [1:0] GNT,
    output logic       BUSY,
    output logic       SS,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] hp_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       last_gnt1;
    logic       hp_done;
    logic       pick1;

    assign hp_done = (hp_cnt == HP_LAST);
    assign MOSI    = tx_sr[7];

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    always_comb begin
        pick1 = REQ1 && (!REQ0 || !last_gnt1);
    end

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            hp_cnt    <= 8'd0;
            bit_cnt   <= 4'd0;
            tx_sr     <= 8'd0;
            rx_sr     <= 8'd0;
            last_gnt1 <= 1'b1;
            GNT       <= 2'b00;
            BUSY      <= 1'b0;
            SS        <= 1'b1;
            SCK       <= 1'b0;
            RDATA     <= 8'd0;
            DONE0     <= 1'b0;
            DONE1     <= 1'b0;
        end else begin
            // NOTE: default-low here makes DONE a single-cycle pulse without extra clearing logic.
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        state     <= SETUP;
                        BUSY      <= 1'b1;
                        SS        <= 1'b0;
                        hp_cnt    <= 8'd0;
                        bit_cnt   <= 4'd0;
                        last_gnt1 <= pick1;
                        GNT       <= pick1 ? 2'b10 : 2'b01;
                        tx_sr     <= pick1 ? WDATA1 : WDATA0;
                    end
                end
                SETUP: begin
                    if (hp_done) begin
                        hp_cnt <= 8'd0;
                        SCK    <= 1'b1;
                        rx_sr  <= {rx_sr[6:0], MISO};
                        state  <= XFER;
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                XFER: begin
                    if (hp_done) begin
                        hp_cnt  <= 8'd0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state <= HOLD;
                        end else if (SCK) begin
                            SCK <= 1'b0;
                            // The final falling edge leaves TX alone so MOSI holds the LSB.
                            if (bit_cnt != 4'd14) begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end
                        end else begin
                            SCK   <= 1'b1;
                            rx_sr <= {rx_sr[6:0], MISO};
                        end
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (hp_done) begin
                        hp_cnt <= 8'd0;
                        SS     <= 1'b1;
                        RDATA  <= rx_sr;
                        DONE0  <= GNT[0];
                        DONE1  <= GNT[1];
                        GNT    <= 2'b00;
                        state  <= GAP;
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (hp_done) begin
                        hp_cnt <= 8'd0;
                        BUSY   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: one instance at CLK_DIV=2, one at CLK_DIV=1.
// Cycle 1 is the first PCLK period after the granting edge.
module tb_spi_master_arb;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    logic       req0_a = 1'b0, req1_a = 1'b0;
    logic [7:0] wdata0_a = 8'h00, wdata1_a = 8'h00;
    logic       done0_a, done1_a, busy_a, ss_a, sck_a, mosi_a;
    logic [7:0] rdata_a;
    logic [1:0] gnt_a;
    wire        miso_a;

    logic       req0_b = 1'b0, req1_b = 1'b0;
    logic [7:0] wdata0_b = 8'h00, wdata1_b = 8'h00;
    logic       done0_b, done1_b, busy_b, ss_b, sck_b, mosi_b;
    logic [7:0] rdata_b;
    logic [1:0] gnt_b;
    logic       miso_b = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    spi_master_arb #(.CLK_DIV(2)) dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .REQ0(req0_a), .REQ1(req1_a), .WDATA0(wdata0_a), .WDATA1(wdata1_a),
        .DONE0(done0_a), .DONE1(done1_a), .RDATA(rdata_a), .GNT(gnt_a),
        .BUSY(busy_a), .SS(ss_a), .SCK(sck_a), .MOSI(mosi_a), .MISO(miso_a)
    );

    spi_master_arb #(.CLK_DIV(1)) dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .REQ0(req0_b), .REQ1(req1_b), .WDATA0(wdata0_b), .WDATA1(wdata1_b),
        .DONE0(done0_b), .DONE1(done1_b), .RDATA(rdata_b), .GNT(gnt_b),
        .BUSY(busy_b), .SS(ss_b), .SCK(sck_b), .MOSI(mosi_b), .MISO(miso_b)
    );

    // Mode-0 slave always returning 0x3C: reloads while deselected, shifts on falling SCK.
    logic [7:0] slv_sr_a = 8'h3C;
    assign miso_a = slv_sr_a[7];
    always @(posedge ss_a or negedge sck_a) begin
        if (ss_a) slv_sr_a = 8'h3C;
        else      slv_sr_a = {slv_sr_a[6:0], 1'b0};
    end

    logic [7:0] mosi_cap_a = 8'h00;
    int         rise_a = 0;
    always @(posedge sck_a) begin
        mosi_cap_a = {mosi_cap_a[6:0], mosi_a};
        rise_a++;
    end

    logic [7:0] mosi_cap_b = 8'h00;
    int         rise_b = 0;
    time        last_rise_b = 0;
    time        period_b = 0;
    always @(posedge sck_b) begin
        mosi_cap_b  = {mosi_cap_b[6:0], mosi_b};
        period_b    = $time - last_rise_b;
        last_rise_b = $time;
        rise_b++;
    end

    // Waits for a grant on dut_a, then measures the frame up to its DONE cycle.
    task automatic run_frame_a(input logic chg_w0, input logic [7:0] chg_val, input logic [1:0] next_req,
                               output int done_cyc, output int ss_low, output int first_low,
                               output logic [1:0] gnt_c1, output logic [1:0] done_bits,
                               output logic both_done, output logic gnt_stable, output int rises);
        int wait_n;
        int r0;
        done_cyc = -1; ss_low = 0; first_low = -1; gnt_c1 = 2'b00; done_bits = 2'b00;
        both_done = 1'b0; gnt_stable = 1'b1; rises = 0;
        r0 = rise_a;
        wait_n = 0;
        do begin
            @(negedge PCLK);
            wait_n++;
        end while (gnt_a == 2'b00 && wait_n < 100);
        if (gnt_a == 2'b00) return;
        gnt_c1 = gnt_a;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc > 1) @(negedge PCLK);
            if (!ss_a) begin
                ss_low++;
                if (first_low < 0) first_low = cyc;
            end
            if (done0_a && done1_a) both_done = 1'b1;
            if (done0_a || done1_a) begin
                done_cyc  = cyc;
                done_bits = {done1_a, done0_a};
                {req1_a, req0_a} = next_req;
                break;
            end
            if (gnt_a != gnt_c1) gnt_stable = 1'b0;
            if (cyc == 1 && chg_w0) wdata0_a = chg_val;
        end
        rises = rise_a - r0;
    endtask

    task automatic test_reset();
        req0_a = 1'b1;
        repeat (3) @(negedge PCLK);
        checks++; if (ss_a !== 1'b1)     begin failures++; $display("FAIL reset_ss: got %b want 1", ss_a); end
        checks++; if (sck_a !== 1'b0)    begin failures++; $display("FAIL reset_sck: got %b want 0", sck_a); end
        checks++; if (mosi_a !== 1'b0)   begin failures++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
        checks++; if ({done1_a, done0_a} !== 2'b00) begin failures++; $display("FAIL reset_done: got %b want 00", {done1_a, done0_a}); end
        checks++; if (gnt_a !== 2'b00)   begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt_a); end
        checks++; if (busy_a !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", rdata_a); end
        checks++; if ({gnt_b, ss_b, sck_b} !== 4'b0010) begin failures++; $display("FAIL reset_b: got %b want 0010", {gnt_b, ss_b, sck_b}); end
        req0_a  = 1'b0;
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        checks++; if (busy_a !== 1'b0)   begin failures++; $display("FAIL idle_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_single_frame();
        int dc, sl, fl, rs;
        logic [1:0] g1, db;
        logic bd, gs;
        wdata0_a = 8'hA5;
        req0_a   = 1'b1;
        run_frame_a(1'b0, 8'h00, 2'b00, dc, sl, fl, g1, db, bd, gs, rs);
        checks++; if (dc !== 37)         begin failures++; $display("FAIL single_done_cycle: got %0d want 37", dc); end
        checks++; if (sl !== 36)         begin failures++; $display("FAIL single_ss_low: got %0d want 36", sl); end
        checks++; if (fl !== 1)          begin failures++; $display("FAIL single_ss_first: got %0d want 1", fl); end
        checks++; if (g1 !== 2'b01)      begin failures++; $display("FAIL single_gnt: got %b want 01", g1); end
        checks++; if (db !== 2'b01)      begin failures++; $display("FAIL single_done_bits: got %b want 01", db); end
        checks++; if (gs !== 1'b1)       begin failures++; $display("FAIL single_gnt_stable: got %b want 1", gs); end
        checks++; if (rs !== 8)          begin failures++; $display("FAIL single_rises: got %0d want 8", rs); end
        checks++; if (mosi_cap_a !== 8'hA5) begin failures++; $display("FAIL single_mosi: got %h want a5", mosi_cap_a); end
        checks++; if (rdata_a !== 8'h3C) begin failures++; $display("FAIL single_rdata: got %h want 3c", rdata_a); end
        checks++; if (gnt_a !== 2'b00)   begin failures++; $display("FAIL single_gnt_clear: got %b want 00", gnt_a); end
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_h1_frame();
        int n, cyc, r0;
        r0 = rise_b;
        wdata1_b = 8'hFF;
        req1_b   = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (gnt_b == 2'b00 && n < 50);
        cyc = 1;
        while (!(done0_b || done1_b) && cyc < 100) begin
            @(negedge PCLK);
            cyc++;
        end
        checks++; if (cyc !== 19)        begin failures++; $display("FAIL h1_done_cycle: got %0d want 19", cyc); end
        checks++; if ({done1_b, done0_b} !== 2'b10) begin failures++; $display("FAIL h1_done_bits: got %b want 10", {done1_b, done0_b}); end
        req1_b = 1'b0;
        checks++; if (rdata_b !== 8'h00) begin failures++; $display("FAIL h1_rdata: got %h want 00", rdata_b); end
        checks++; if (mosi_cap_b !== 8'hFF) begin failures++; $display("FAIL h1_mosi: got %h want ff", mosi_cap_b); end
        checks++; if (rise_b - r0 !== 8) begin failures++; $display("FAIL h1_rises: got %0d want 8", rise_b - r0); end
        checks++; if (period_b !== 20)   begin failures++; $display("FAIL h1_sck_period: got %0t want 20", period_b); end
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_wdata_change();
        int dc, sl, fl, rs;
        logic [1:0] g1, db;
        logic bd, gs;
        wdata0_a = 8'h81;
        req0_a   = 1'b1;
        run_frame_a(1'b1, 8'h00, 2'b00, dc, sl, fl, g1, db, bd, gs, rs);
        checks++; if (mosi_cap_a !== 8'h81) begin failures++; $display("FAIL wchg_mosi: got %h want 81", mosi_cap_a); end
        checks++; if (dc !== 37)         begin failures++; $display("FAIL wchg_done_cycle: got %0d want 37", dc); end
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_round_robin();
        int dc, sl, fl, rs;
        logic [1:0] g1, db;
        logic bd, gs;
        logic [1:0] exp_g;
        logic [7:0] exp_m;
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn  = 1'b1;
        wdata0_a = 8'h11;
        wdata1_a = 8'h22;
        req0_a   = 1'b1;
        req1_a   = 1'b1;
        for (int f = 0; f < 4; f++) begin
            exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
            exp_m = (f % 2 == 0) ? 8'h11 : 8'h22;
            run_frame_a(1'b0, 8'h00, (f == 3) ? 2'b00 : 2'b11, dc, sl, fl, g1, db, bd, gs, rs);
            checks++; if (g1 !== exp_g)   begin failures++; $display("FAIL rr_gnt f%0d: got %b want %b", f, g1, exp_g); end
            checks++; if (db !== exp_g)   begin failures++; $display("FAIL rr_done f%0d: got %b want %b", f, db, exp_g); end
            checks++; if (bd !== 1'b0)    begin failures++; $display("FAIL rr_both_done f%0d: got %b want 0", f, bd); end
            checks++; if (gs !== 1'b1)    begin failures++; $display("FAIL rr_gnt_stable f%0d: got %b want 1", f, gs); end
            checks++; if (dc !== 37)      begin failures++; $display("FAIL rr_done_cycle f%0d: got %0d want 37", f, dc); end
            checks++; if (mosi_cap_a !== exp_m) begin failures++; $display("FAIL rr_mosi f%0d: got %h want %h", f, mosi_cap_a, exp_m); end
            checks++; if (rdata_a !== 8'h3C) begin failures++; $display("FAIL rr_rdata f%0d: got %h want 3c", f, rdata_a); end
        end
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_gap_request();
        int dc, sl, fl, rs, n;
        logic [1:0] g1, db;
        logic bd, gs;
        wdata0_a = 8'h5A;
        wdata1_a = 8'h96;
        req0_a   = 1'b1;
        run_frame_a(1'b0, 8'h00, 2'b10, dc, sl, fl, g1, db, bd, gs, rs);
        checks++; if (dc !== 37)         begin failures++; $display("FAIL gap_done_cycle: got %0d want 37", dc); end
        @(negedge PCLK);
        checks++; if ({gnt_a, busy_a} !== 3'b001) begin failures++; $display("FAIL gap_c38: got %b want 001", {gnt_a, busy_a}); end
        @(negedge PCLK);
        checks++; if ({gnt_a, busy_a} !== 3'b000) begin failures++; $display("FAIL gap_c39: got %b want 000", {gnt_a, busy_a}); end
        @(negedge PCLK);
        checks++; if (gnt_a !== 2'b10)   begin failures++; $display("FAIL gap_grant_c40: got %b want 10", gnt_a); end
        n = 0;
        while (!done1_a && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        checks++; if (done1_a !== 1'b1)  begin failures++; $display("FAIL gap_done1: got %b want 1", done1_a); end
        req1_a = 1'b0;
        checks++; if (mosi_cap_a !== 8'h96) begin failures++; $display("FAIL gap_mosi: got %h want 96", mosi_cap_a); end
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_reset_midframe();
        int dc, sl, fl, rs, n;
        logic [1:0] g1, db;
        logic bd, gs;
        logic saw_done;
        wdata0_a = 8'hC3;
        req0_a   = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (gnt_a == 2'b00 && n < 100);
        repeat (9) @(negedge PCLK);
        checks++; if ({busy_a, ss_a} !== 2'b10) begin failures++; $display("FAIL mid_active: got %b want 10", {busy_a, ss_a}); end
        PRESETn = 1'b0;
        #1;
        checks++; if ({ss_a, sck_a} !== 2'b10) begin failures++; $display("FAIL mid_abort_pins: got %b want 10", {ss_a, sck_a}); end
        checks++; if ({gnt_a, busy_a} !== 3'b000) begin failures++; $display("FAIL mid_abort_state: got %b want 000", {gnt_a, busy_a}); end
        checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL mid_abort_rdata: got %h want 00", rdata_a); end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            if (done0_a || done1_a) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL mid_no_done: got %b want 0", saw_done); end
        PRESETn = 1'b1;
        run_frame_a(1'b0, 8'h00, 2'b00, dc, sl, fl, g1, db, bd, gs, rs);
        checks++; if (dc !== 37)         begin failures++; $display("FAIL mid_restart_done: got %0d want 37", dc); end
        checks++; if (db !== 2'b01)      begin failures++; $display("FAIL mid_restart_bits: got %b want 01", db); end
        checks++; if (mosi_cap_a !== 8'hC3) begin failures++; $display("FAIL mid_restart_mosi: got %h want c3", mosi_cap_a); end
        checks++; if (rdata_a !== 8'h3C) begin failures++; $display("FAIL mid_restart_rdata: got %h want 3c", rdata_a); end
        repeat (4) @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_h1_frame();
        test_wdata_change();
        test_round_robin();
        test_gap_request();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
